// File: rtl/cmd_seq_pkg.sv
// -----------------------------------------------------------------------------
// cmd_seq_pkg
// Shared definitions for the UART command sequencer:
//   - host opcodes (first byte of every frame)
//   - register-file addresses that receive the ALU operands
//   - state encodings of the main sequencer FSM and of the TX frame sender
//   - in_alu_path(): tells which main states keep the ALU clock gate open
// -----------------------------------------------------------------------------
package cmd_seq_pkg;

    localparam logic [7:0] CMD_WR     = 8'hAA;
    localparam logic [7:0] CMD_RD     = 8'hBB;
    localparam logic [7:0] CMD_ALU_OP = 8'hCC;
    localparam logic [7:0] CMD_ALU    = 8'hDD;

    localparam logic [3:0] OPA_ADDR = 4'h0;
    localparam logic [3:0] OPB_ADDR = 4'h1;

    typedef enum logic [3:0] {
        IDLE      = 4'd0,
        WR_ADDR   = 4'd1,
        WR_DATA   = 4'd2,
        RD_ADDR   = 4'd3,
        RD_WAIT   = 4'd4,
        OP_A      = 4'd5,
        OP_B      = 4'd6,
        ALU_FUN_S = 4'd7,
        ALU_WAIT  = 4'd8,
        TX_SEND   = 4'd9,
        TX_WAIT   = 4'd10
    } seq_state_e;

    typedef enum logic [1:0] {
        TXS_IDLE    = 2'd0,
        TXS_SEND    = 2'd1,
        TXS_WAIT_HI = 2'd2,
        TXS_WAIT_LO = 2'd3
    } tx_state_e;

    // The ALU clock gate is open only while an ALU command is being collected
    // or its result awaited; TX of the result runs with the gate closed.
    function automatic logic in_alu_path(input seq_state_e st);
        case (st)
            OP_A, OP_B, ALU_FUN_S, ALU_WAIT: return 1'b1;
            default:                         return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/tx_frame_sender.sv
// -----------------------------------------------------------------------------
// tx_frame_sender
// Sends a 1- or 2-byte frame to the UART transmitter, LSB first.
// For every byte: strobe TX_D_VLD for one cycle while TX_Busy is low, then
// wait for TX_Busy to rise and fall again before the next byte / done.
// Ports:
//   CLK, RST   clock, synchronous active-high reset
//   start      1-cycle request; data and len are captured with it
//   abort      drop the frame immediately and return to idle
//   len        number of bytes to send (2'd1 or 2'd2)
//   data       frame word, byte 0 = data[7:0]
//   TX_Busy    UART transmitter busy
//   TX_P_DATA  byte to transmit (valid with TX_D_VLD, otherwise 0)
//   TX_D_VLD   1-cycle transmit strobe
//   done       1-cycle pulse after the last byte has left the transmitter
// -----------------------------------------------------------------------------
module tx_frame_sender
    import cmd_seq_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int WORD_WIDTH = 16
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  start,
    input  logic                  abort,
    input  logic [1:0]            len,
    input  logic [WORD_WIDTH-1:0] data,
    input  logic                  TX_Busy,
    output logic [DATA_WIDTH-1:0] TX_P_DATA,
    output logic                  TX_D_VLD,
    output logic                  done
);

    tx_state_e               state_r, state_s;
    logic [WORD_WIDTH-1:0]   data_r, data_s;
    logic                    last_r, last_s;
    logic [DATA_WIDTH-1:0]   tx_data_r, tx_data_s;
    logic                    tx_vld_r, tx_vld_s;
    logic                    done_r, done_s;

    // Next-state and next-output logic of the byte handshake.
    always_comb begin
        state_s   = state_r;
        data_s    = data_r;
        last_s    = last_r;
        tx_data_s = {DATA_WIDTH{1'b0}};
        tx_vld_s  = 1'b0;
        done_s    = 1'b0;
        if (abort) begin
            state_s = TXS_IDLE;
            data_s  = {WORD_WIDTH{1'b0}};
            last_s  = 1'b0;
        end else begin
            case (state_r)
                TXS_IDLE: begin
                    if (start) begin
                        data_s  = data;
                        last_s  = (len != 2'd2);
                        state_s = TXS_SEND;
                    end else begin
                        state_s = TXS_IDLE;
                    end
                end
                TXS_SEND: begin
                    if (!TX_Busy) begin
                        tx_vld_s  = 1'b1;
                        tx_data_s = data_r[DATA_WIDTH-1:0];
                        state_s   = TXS_WAIT_HI;
                    end else begin
                        state_s = TXS_SEND;
                    end
                end
                TXS_WAIT_HI: begin
                    if (TX_Busy) begin
                        state_s = TXS_WAIT_LO;
                    end else begin
                        state_s = TXS_WAIT_HI;
                    end
                end
                TXS_WAIT_LO: begin
                    if (!TX_Busy) begin
                        if (last_r) begin
                            done_s  = 1'b1;
                            state_s = TXS_IDLE;
                        end else begin
                            // Move the MSB down so TXS_SEND always sends data_r[7:0].
                            data_s  = data_r >> DATA_WIDTH;
                            last_s  = 1'b1;
                            state_s = TXS_SEND;
                        end
                    end else begin
                        state_s = TXS_WAIT_LO;
                    end
                end
                default: begin
                    state_s = TXS_IDLE;
                end
            endcase
        end
    end

    // Handshake state and registered TX outputs.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_r   <= TXS_IDLE;
            data_r    <= {WORD_WIDTH{1'b0}};
            last_r    <= 1'b0;
            tx_data_r <= {DATA_WIDTH{1'b0}};
            tx_vld_r  <= 1'b0;
            done_r    <= 1'b0;
        end else begin
            state_r   <= state_s;
            data_r    <= data_s;
            last_r    <= last_s;
            tx_data_r <= tx_data_s;
            tx_vld_r  <= tx_vld_s;
            done_r    <= done_s;
        end
    end

    assign TX_P_DATA = tx_data_r;
    assign TX_D_VLD  = tx_vld_r;
    assign done      = done_r;

endmodule

// File: rtl/uart_cmd_sequencer.sv
// -----------------------------------------------------------------------------
// uart_cmd_sequencer
// Host-driven command controller between UART RX/TX, register file, ALU and
// the ALU clock gate. Byte frames (opcode first):
//   AA addr data     register-file write
//   BB addr          register-file read, read byte returned over TX
//   CC A B fun       A -> RF[0], B -> RF[1], then run ALU function fun
//   DD fun           run ALU function fun, 16-bit result returned LSB first
// A frame that stalls for TIMEOUT_CYCLES cycles is aborted with Cmd_Error.
// Ports:
//   CLK, RST                     clock, synchronous active-high reset
//   RX_P_DATA, RX_D_VLD          received byte and its 1-cycle strobe
//   RF_WrEn, RF_RdEn             register-file write / read strobes
//   RF_Address, RF_WrData        register-file address and write data
//   RF_RdData, RF_RdData_VLD     register-file read data and valid
//   ALU_EN, ALU_FUN              1-cycle ALU start, function (held to IDLE)
//   ALU_OUT, ALU_OUT_VLD         ALU result and valid
//   CLKG_EN                      ALU clock-gate enable
//   TX_P_DATA, TX_D_VLD, TX_Busy UART transmit byte, strobe, busy
//   Cmd_Error                    1-cycle pulse on bad opcode or timeout
// All outputs are registered.
// -----------------------------------------------------------------------------
module uart_cmd_sequencer
    import cmd_seq_pkg::*;
#(
    parameter int DATA_WIDTH     = 8,
    parameter int ADDR_WIDTH     = 4,
    parameter int ALU_OUT_WIDTH  = 16,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic [DATA_WIDTH-1:0]    RX_P_DATA,
    input  logic                     RX_D_VLD,
    output logic                     RF_WrEn,
    output logic                     RF_RdEn,
    output logic [ADDR_WIDTH-1:0]    RF_Address,
    output logic [DATA_WIDTH-1:0]    RF_WrData,
    input  logic [DATA_WIDTH-1:0]    RF_RdData,
    input  logic                     RF_RdData_VLD,
    output logic                     ALU_EN,
    output logic [3:0]               ALU_FUN,
    input  logic [ALU_OUT_WIDTH-1:0] ALU_OUT,
    input  logic                     ALU_OUT_VLD,
    output logic                     CLKG_EN,
    output logic [DATA_WIDTH-1:0]    TX_P_DATA,
    output logic                     TX_D_VLD,
    input  logic                     TX_Busy,
    output logic                     Cmd_Error
);

    localparam int                  TIMER_W    = $clog2(TIMEOUT_CYCLES);
    localparam logic [TIMER_W-1:0]  TIMER_LAST = TIMER_W'(TIMEOUT_CYCLES - 1);

    seq_state_e               state_r, state_s;
    logic [TIMER_W-1:0]       timer_r, timer_s;
    logic [ADDR_WIDTH-1:0]    wr_addr_r, wr_addr_s;
    logic [ALU_OUT_WIDTH-1:0] result_r, result_s;
    logic [1:0]               tx_len_r, tx_len_s;

    logic                     rf_wr_en_r, rf_wr_en_s;
    logic                     rf_rd_en_r, rf_rd_en_s;
    logic [ADDR_WIDTH-1:0]    rf_addr_r, rf_addr_s;
    logic [DATA_WIDTH-1:0]    rf_wr_data_r, rf_wr_data_s;
    logic                     alu_en_r, alu_en_s;
    logic [3:0]               alu_fun_r, alu_fun_s;
    logic                     clkg_en_r;
    logic                     cmd_error_r, cmd_error_s;

    logic                     timeout_s;
    logic                     tx_start_s;
    logic                     tx_abort_s;
    logic                     tx_done_s;

    assign timeout_s = (state_r != IDLE) && (timer_r == TIMER_LAST);

    // Frame parsing: next state, frame context and next output values.
    always_comb begin
        state_s      = state_r;
        wr_addr_s    = wr_addr_r;
        result_s     = result_r;
        tx_len_s     = tx_len_r;
        rf_wr_en_s   = 1'b0;
        rf_rd_en_s   = 1'b0;
        rf_addr_s    = rf_addr_r;
        rf_wr_data_s = rf_wr_data_r;
        alu_en_s     = 1'b0;
        alu_fun_s    = alu_fun_r;
        cmd_error_s  = 1'b0;
        tx_start_s   = 1'b0;
        tx_abort_s   = 1'b0;
        if (timeout_s) begin
            // Timeout beats a byte arriving in the same cycle; that byte is lost.
            state_s      = IDLE;
            cmd_error_s  = 1'b1;
            tx_abort_s   = 1'b1;
            wr_addr_s    = {ADDR_WIDTH{1'b0}};
            result_s     = {ALU_OUT_WIDTH{1'b0}};
            tx_len_s     = 2'd0;
            rf_addr_s    = {ADDR_WIDTH{1'b0}};
            rf_wr_data_s = {DATA_WIDTH{1'b0}};
        end else begin
            case (state_r)
                IDLE: begin
                    if (RX_D_VLD) begin
                        case (RX_P_DATA)
                            CMD_WR:     state_s = WR_ADDR;
                            CMD_RD:     state_s = RD_ADDR;
                            CMD_ALU_OP: state_s = OP_A;
                            CMD_ALU:    state_s = ALU_FUN_S;
                            default:    cmd_error_s = 1'b1;
                        endcase
                    end else begin
                        state_s = IDLE;
                    end
                end
                WR_ADDR: begin
                    if (RX_D_VLD) begin
                        wr_addr_s = RX_P_DATA[ADDR_WIDTH-1:0];
                        state_s   = WR_DATA;
                    end else begin
                        state_s = WR_ADDR;
                    end
                end
                WR_DATA: begin
                    if (RX_D_VLD) begin
                        rf_wr_en_s   = 1'b1;
                        rf_addr_s    = wr_addr_r;
                        rf_wr_data_s = RX_P_DATA;
                        state_s      = IDLE;
                    end else begin
                        state_s = WR_DATA;
                    end
                end
                RD_ADDR: begin
                    if (RX_D_VLD) begin
                        rf_rd_en_s = 1'b1;
                        rf_addr_s  = RX_P_DATA[ADDR_WIDTH-1:0];
                        state_s    = RD_WAIT;
                    end else begin
                        state_s = RD_ADDR;
                    end
                end
                RD_WAIT: begin
                    if (RF_RdData_VLD) begin
                        result_s = ALU_OUT_WIDTH'(RF_RdData);
                        tx_len_s = 2'd1;
                        state_s  = TX_SEND;
                    end else begin
                        state_s = RD_WAIT;
                    end
                end
                OP_A: begin
                    if (RX_D_VLD) begin
                        rf_wr_en_s   = 1'b1;
                        rf_addr_s    = ADDR_WIDTH'(OPA_ADDR);
                        rf_wr_data_s = RX_P_DATA;
                        state_s      = OP_B;
                    end else begin
                        state_s = OP_A;
                    end
                end
                OP_B: begin
                    if (RX_D_VLD) begin
                        rf_wr_en_s   = 1'b1;
                        rf_addr_s    = ADDR_WIDTH'(OPB_ADDR);
                        rf_wr_data_s = RX_P_DATA;
                        state_s      = ALU_FUN_S;
                    end else begin
                        state_s = OP_B;
                    end
                end
                ALU_FUN_S: begin
                    if (RX_D_VLD) begin
                        alu_en_s  = 1'b1;
                        alu_fun_s = RX_P_DATA[3:0];
                        state_s   = ALU_WAIT;
                    end else begin
                        state_s = ALU_FUN_S;
                    end
                end
                ALU_WAIT: begin
                    if (ALU_OUT_VLD) begin
                        result_s = ALU_OUT;
                        tx_len_s = 2'd2;
                        state_s  = TX_SEND;
                    end else begin
                        state_s = ALU_WAIT;
                    end
                end
                TX_SEND: begin
                    tx_start_s = 1'b1;
                    state_s    = TX_WAIT;
                end
                TX_WAIT: begin
                    if (tx_done_s) begin
                        state_s = IDLE;
                    end else begin
                        state_s = TX_WAIT;
                    end
                end
                default: begin
                    state_s = IDLE;
                end
            endcase
        end

        // Every accepted byte moves the FSM to another state (a bad opcode
        // leaves it in IDLE, where the timer is idle anyway), so clearing on a
        // state change also covers clearing on byte acceptance.
        if ((state_s != state_r) || (state_r == IDLE)) begin
            timer_s = {TIMER_W{1'b0}};
        end else begin
            timer_s = timer_r + TIMER_W'(1);
        end
    end

    // Sequencer state, timer, frame context and registered outputs.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_r      <= IDLE;
            timer_r      <= {TIMER_W{1'b0}};
            wr_addr_r    <= {ADDR_WIDTH{1'b0}};
            result_r     <= {ALU_OUT_WIDTH{1'b0}};
            tx_len_r     <= 2'd0;
            rf_wr_en_r   <= 1'b0;
            rf_rd_en_r   <= 1'b0;
            rf_addr_r    <= {ADDR_WIDTH{1'b0}};
            rf_wr_data_r <= {DATA_WIDTH{1'b0}};
            alu_en_r     <= 1'b0;
            alu_fun_r    <= 4'h0;
            clkg_en_r    <= 1'b0;
            cmd_error_r  <= 1'b0;
        end else begin
            state_r      <= state_s;
            timer_r      <= timer_s;
            wr_addr_r    <= wr_addr_s;
            result_r     <= result_s;
            tx_len_r     <= tx_len_s;
            rf_wr_en_r   <= rf_wr_en_s;
            rf_rd_en_r   <= rf_rd_en_s;
            rf_addr_r    <= rf_addr_s;
            rf_wr_data_r <= rf_wr_data_s;
            alu_en_r     <= alu_en_s;
            // ALU_FUN stays valid for the whole operation and clears on return to IDLE.
            alu_fun_r    <= (state_s == IDLE) ? 4'h0 : alu_fun_s;
            // Registered from the next state, so the gate opens on entry to OP_A
            // or ALU_FUN_S, at least one cycle ahead of ALU_EN.
            clkg_en_r    <= in_alu_path(state_s);
            cmd_error_r  <= cmd_error_s;
        end
    end

    tx_frame_sender #(
        .DATA_WIDTH (DATA_WIDTH),
        .WORD_WIDTH (ALU_OUT_WIDTH)
    ) u_tx (
        .CLK       (CLK),
        .RST       (RST),
        .start     (tx_start_s),
        .abort     (tx_abort_s),
        .len       (tx_len_r),
        .data      (result_r),
        .TX_Busy   (TX_Busy),
        .TX_P_DATA (TX_P_DATA),
        .TX_D_VLD  (TX_D_VLD),
        .done      (tx_done_s)
    );

    assign RF_WrEn    = rf_wr_en_r;
    assign RF_RdEn    = rf_rd_en_r;
    assign RF_Address = rf_addr_r;
    assign RF_WrData  = rf_wr_data_r;
    assign ALU_EN     = alu_en_r;
    assign ALU_FUN    = alu_fun_r;
    assign CLKG_EN    = clkg_en_r;
    assign Cmd_Error  = cmd_error_r;

endmodule

// File: tb/tb_uart_cmd_sequencer.sv
// -----------------------------------------------------------------------------
// tb_uart_cmd_sequencer
// Directed bench for uart_cmd_sequencer. Simple models of the register file
// (read data valid 2 cycles after RF_RdEn), ALU (result valid 3 cycles after
// ALU_EN) and UART TX (busy for 4 cycles after each strobe, optionally held
// busy) run on the falling edge alongside the directed frames.
// -----------------------------------------------------------------------------
module tb_uart_cmd_sequencer;

    localparam int TIMEOUT = 1024;

    logic        CLK = 1'b0;
    logic        RST;
    logic [7:0]  RX_P_DATA;
    logic        RX_D_VLD;
    logic        RF_WrEn;
    logic        RF_RdEn;
    logic [3:0]  RF_Address;
    logic [7:0]  RF_WrData;
    logic [7:0]  RF_RdData;
    logic        RF_RdData_VLD;
    logic        ALU_EN;
    logic [3:0]  ALU_FUN;
    logic [15:0] ALU_OUT;
    logic        ALU_OUT_VLD;
    logic        CLKG_EN;
    logic [7:0]  TX_P_DATA;
    logic        TX_D_VLD;
    logic        TX_Busy;
    logic        Cmd_Error;

    uart_cmd_sequencer #(
        .DATA_WIDTH     (8),
        .ADDR_WIDTH     (4),
        .ALU_OUT_WIDTH  (16),
        .TIMEOUT_CYCLES (TIMEOUT)
    ) dut (
        .CLK           (CLK),
        .RST           (RST),
        .RX_P_DATA     (RX_P_DATA),
        .RX_D_VLD      (RX_D_VLD),
        .RF_WrEn       (RF_WrEn),
        .RF_RdEn       (RF_RdEn),
        .RF_Address    (RF_Address),
        .RF_WrData     (RF_WrData),
        .RF_RdData     (RF_RdData),
        .RF_RdData_VLD (RF_RdData_VLD),
        .ALU_EN        (ALU_EN),
        .ALU_FUN       (ALU_FUN),
        .ALU_OUT       (ALU_OUT),
        .ALU_OUT_VLD   (ALU_OUT_VLD),
        .CLKG_EN       (CLKG_EN),
        .TX_P_DATA     (TX_P_DATA),
        .TX_D_VLD      (TX_D_VLD),
        .TX_Busy       (TX_Busy),
        .Cmd_Error     (Cmd_Error)
    );

    // 100 MHz style free-running clock.
    always #5 CLK = ~CLK;

    int          n_cmp = 0;
    int          n_err = 0;

    logic [7:0]  tx_log[$];
    int          wr_cnt   = 0;
    int          err_cnt  = 0;
    int          tx_viol  = 0;
    logic [7:0]  rf_val   = 8'h00;
    logic [15:0] alu_val  = 16'h0000;
    bit          alu_auto = 1'b1;
    bit          busy_hold = 1'b0;
    int          late_req = 0;
    int          late_done = 0;
    int          rd_cnt   = 0;
    int          alu_cnt  = 0;
    int          busy_cnt = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] tx_at(input int idx);
        if (idx < tx_log.size()) return tx_log[idx];
        else return 8'hxx;
    endfunction

    // Called at a falling edge; the byte is taken on the next rising edge and
    // the task returns at the falling edge right after it.
    task automatic send_byte(input logic [7:0] b);
        RX_P_DATA = b;
        RX_D_VLD  = 1'b1;
        @(negedge CLK);
        RX_D_VLD  = 1'b0;
        RX_P_DATA = 8'h00;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge CLK);
    endtask

    // Peripheral models and event counters, evaluated on the falling edge.
    initial begin
        RF_RdData     = 8'h00;
        RF_RdData_VLD = 1'b0;
        ALU_OUT       = 16'h0000;
        ALU_OUT_VLD   = 1'b0;
        TX_Busy       = 1'b0;
        forever begin
            @(negedge CLK);
            if (TX_D_VLD) begin
                if (TX_Busy) tx_viol++;
                tx_log.push_back(TX_P_DATA);
                busy_cnt = 4;
            end else if (busy_cnt > 0) begin
                busy_cnt--;
            end
            TX_Busy = busy_hold || (busy_cnt != 0);

            RF_RdData_VLD = 1'b0;
            if (rd_cnt != 0) begin
                rd_cnt--;
                if (rd_cnt == 0) begin
                    RF_RdData_VLD = 1'b1;
                    RF_RdData     = rf_val;
                end
            end
            if (RF_RdEn) rd_cnt = 2;

            ALU_OUT_VLD = 1'b0;
            if (alu_cnt != 0) begin
                alu_cnt--;
                if (alu_cnt == 0) begin
                    ALU_OUT_VLD = 1'b1;
                    ALU_OUT     = alu_val;
                end
            end
            if (ALU_EN && alu_auto) alu_cnt = 3;
            if (late_req != late_done) begin
                ALU_OUT_VLD = 1'b1;
                ALU_OUT     = alu_val;
                late_done   = late_req;
            end

            if (RF_WrEn) wr_cnt++;
            if (Cmd_Error) err_cnt++;
        end
    end

    // Directed frames.
    initial begin
        int base_tx;
        int base_wr;
        int base_err;
        int n;

        RST       = 1'b1;
        RX_D_VLD  = 1'b0;
        RX_P_DATA = 8'h00;
        idle(3);
        check_eq("rst_rf",  {RF_WrEn, RF_RdEn, RF_Address, RF_WrData}, 32'h0);
        check_eq("rst_alu", {ALU_EN, ALU_FUN, CLKG_EN}, 32'h0);
        check_eq("rst_tx",  {TX_D_VLD, TX_P_DATA, Cmd_Error}, 32'h0);
        RST = 1'b0;
        idle(2);

        // Register write AA 05 3C.
        base_wr = wr_cnt;
        base_tx = tx_log.size();
        send_byte(8'hAA);
        send_byte(8'h05);
        send_byte(8'h3C);
        check_eq("wr_strobe", {RF_WrEn, RF_Address, RF_WrData}, {19'h0, 1'b1, 4'h5, 8'h3C});
        idle(1);
        check_eq("wr_one_cycle", RF_WrEn, 32'h0);
        idle(10);
        check_eq("wr_count", wr_cnt - base_wr, 32'd1);
        check_eq("wr_no_tx", tx_log.size() - base_tx, 32'd0);

        // Register read BB 02 returning 7E.
        rf_val  = 8'h7E;
        base_tx = tx_log.size();
        send_byte(8'hBB);
        send_byte(8'h02);
        check_eq("rd_strobe", {RF_RdEn, RF_Address}, {27'h0, 1'b1, 4'h2});
        idle(1);
        check_eq("rd_one_cycle", RF_RdEn, 32'h0);
        idle(20);
        check_eq("rd_tx_count", tx_log.size() - base_tx, 32'd1);
        check_eq("rd_tx_byte", tx_at(base_tx), 32'h7E);

        // Operands plus ALU: CC 10 20 00, result 0030.
        alu_val = 16'h0030;
        base_tx = tx_log.size();
        send_byte(8'hCC);
        check_eq("op_gate_open", CLKG_EN, 32'h1);
        send_byte(8'h10);
        check_eq("op_a_write", {RF_WrEn, RF_Address, RF_WrData}, {19'h0, 1'b1, 4'h0, 8'h10});
        send_byte(8'h20);
        check_eq("op_b_write", {RF_WrEn, RF_Address, RF_WrData}, {19'h0, 1'b1, 4'h1, 8'h20});
        send_byte(8'h00);
        check_eq("op_alu_start", {ALU_EN, ALU_FUN, CLKG_EN}, {26'h0, 1'b1, 4'h0, 1'b1});
        idle(1);
        check_eq("op_alu_en_pulse", ALU_EN, 32'h0);
        idle(30);
        check_eq("op_tx_count", tx_log.size() - base_tx, 32'd2);
        check_eq("op_tx_lsb", tx_at(base_tx), 32'h30);
        check_eq("op_tx_msb", tx_at(base_tx + 1), 32'h00);
        check_eq("op_gate_closed", {CLKG_EN, ALU_FUN}, 32'h0);

        // ALU DD 02 with the transmitter busy for 50 cycles.
        alu_val   = 16'hBEEF;
        busy_hold = 1'b1;
        base_tx   = tx_log.size();
        send_byte(8'hDD);
        check_eq("alu_gate_early", {CLKG_EN, ALU_EN}, 32'h2);
        send_byte(8'h02);
        check_eq("alu_start", {ALU_EN, ALU_FUN}, {27'h0, 1'b1, 4'h2});
        idle(50);
        check_eq("alu_tx_withheld", tx_log.size() - base_tx, 32'd0);
        check_eq("alu_fun_held", ALU_FUN, 32'h2);
        busy_hold = 1'b0;
        idle(30);
        check_eq("alu_tx_count", tx_log.size() - base_tx, 32'd2);
        check_eq("alu_tx_lsb", tx_at(base_tx), 32'hEF);
        check_eq("alu_tx_msb", tx_at(base_tx + 1), 32'hBE);
        check_eq("tx_busy_violations", tx_viol, 32'd0);

        // Bad opcode, then a write frame abandoned after its address byte.
        send_byte(8'h55);
        check_eq("bad_op_error", Cmd_Error, 32'h1);
        idle(1);
        check_eq("bad_op_pulse", Cmd_Error, 32'h0);
        base_wr = wr_cnt;
        send_byte(8'hAA);
        send_byte(8'h05);
        n = 0;
        while (!Cmd_Error && (n < TIMEOUT + 50)) begin
            @(negedge CLK);
            n++;
        end
        check_eq("timeout_cycles", n, TIMEOUT);
        check_eq("timeout_outputs", {RF_WrEn, CLKG_EN, TX_D_VLD}, 32'h0);
        idle(2);
        check_eq("timeout_pulse", Cmd_Error, 32'h0);
        check_eq("timeout_no_write", wr_cnt - base_wr, 32'd0);

        // Reset while waiting for the ALU; the late result must be ignored.
        alu_auto = 1'b0;
        alu_val  = 16'h1234;
        send_byte(8'hDD);
        send_byte(8'h03);
        idle(3);
        check_eq("alu_wait_state", {CLKG_EN, ALU_FUN}, {27'h0, 1'b1, 4'h3});
        RST = 1'b1;
        idle(1);
        check_eq("mid_rst_outputs",
                 {RF_WrEn, RF_RdEn, RF_Address, RF_WrData, ALU_EN, ALU_FUN,
                  CLKG_EN, TX_D_VLD, TX_P_DATA, Cmd_Error}, 32'h0);
        RST      = 1'b0;
        base_tx  = tx_log.size();
        base_err = err_cnt;
        late_req++;
        idle(20);
        check_eq("late_vld_no_tx", tx_log.size() - base_tx, 32'd0);
        check_eq("late_vld_no_err", err_cnt - base_err, 32'd0);
        alu_auto = 1'b1;
        base_wr  = wr_cnt;
        send_byte(8'hAA);
        send_byte(8'hF7);
        send_byte(8'h5A);
        check_eq("post_rst_write", {RF_WrEn, RF_Address, RF_WrData}, {19'h0, 1'b1, 4'h7, 8'h5A});
        idle(5);
        check_eq("post_rst_count", wr_cnt - base_wr, 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
